// File: rtl/demux6b2_stream.sv
// rtl/demux6b2_stream.sv - registered 1-to-2 stream demux with a per-lane FIFO
// Each accepted word is steered by s into lane a (s=0) or lane b (s=1).

module demux6b2_lane #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 2,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [PW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      count_q, count_d;
  logic             pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = valid_o ? mem_q[rptr_q] : '0;
  assign pop     = valid_o && ready_i;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + PW'(1);
    if (pop)    rptr_d = rptr_q + PW'(1);
    case ({push_i, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; a zero count hides stale contents.
  always_ff @(posedge clk) begin
    if (push_i && !reset) mem_q[wptr_q] <= wdata_i;
  end

endmodule

module demux6b2_stream #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 2,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [PW:0]      a_count,
  output logic [PW:0]      b_count,
  output logic             busy
);

  logic a_full, b_full;
  logic push_a, push_b;

  // A full lane refuses even when it pops in the same cycle.
  assign in_ready = s ? !b_full : !a_full;
  assign push_a   = in_valid && in_ready && !s;
  assign push_b   = in_valid && in_ready &&  s;
  assign busy     = a_valid | b_valid;

  demux6b2_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_lane_a (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_a),
    .wdata_i (in_data),
    .ready_i (a_ready),
    .data_o  (a_data),
    .valid_o (a_valid),
    .full_o  (a_full),
    .count_o (a_count)
  );

  demux6b2_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_lane_b (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_b),
    .wdata_i (in_data),
    .ready_i (b_ready),
    .data_o  (b_data),
    .valid_o (b_valid),
    .full_o  (b_full),
    .count_o (b_count)
  );

endmodule

// File: tb/tb_demux6b2_stream.sv
// tb/tb_demux6b2_stream.sv - scoreboard bench for demux6b2_stream
module tb_demux6b2_stream;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] in_data;
  logic       s;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [1:0] a_count, b_count;
  logic       busy;

  int compared = 0;
  int mismatched = 0;
  logic [5:0] qa[$];
  logic [5:0] qb[$];
  logic [5:0] e;
  logic       exp_rdy;

  always #5 clk = ~clk;

  demux6b2_stream #(.WIDTH(6), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .s(s), .in_valid(in_valid),
    .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count), .busy(busy)
  );

  // Inputs change and outputs are observed at the falling edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; s = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    next_cycle(); next_cycle();
    reset = 1'b0;
    next_cycle();
    qa.delete(); qb.delete();
    compared++; if (a_valid !== 1'b0) begin mismatched++; $display("FAIL rst_a_valid got=%0h exp=0", a_valid); end
    compared++; if (b_valid !== 1'b0) begin mismatched++; $display("FAIL rst_b_valid got=%0h exp=0", b_valid); end
    compared++; if (a_count !== 2'd0) begin mismatched++; $display("FAIL rst_a_count got=%0d exp=0", a_count); end
    compared++; if (b_count !== 2'd0) begin mismatched++; $display("FAIL rst_b_count got=%0d exp=0", b_count); end
    compared++; if (a_data !== 6'h00) begin mismatched++; $display("FAIL rst_a_data got=%0h exp=0", a_data); end
    compared++; if (b_data !== 6'h00) begin mismatched++; $display("FAIL rst_b_data got=%0h exp=0", b_data); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    s = 1'b0; #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_in_ready_s0 got=%0h exp=1", in_ready); end
    s = 1'b1; #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_in_ready_s1 got=%0h exp=1", in_ready); end
  endtask

  task automatic test_single_a();
    next_cycle();
    s = 1'b0; in_data = 6'h15; in_valid = 1'b1; a_ready = 1'b0; #1;
    exp_rdy = (qa.size() != DEPTH);
    compared++; if (in_ready !== exp_rdy) begin mismatched++; $display("FAIL single_in_ready got=%0h exp=%0h", in_ready, exp_rdy); end
    if (exp_rdy) qa.push_back(in_data);
    next_cycle();
    in_valid = 1'b0;
    compared++; if (a_valid !== 1'b1) begin mismatched++; $display("FAIL single_a_valid got=%0h exp=1", a_valid); end
    compared++; if (a_count !== 2'(qa.size())) begin mismatched++; $display("FAIL single_a_count got=%0d exp=%0d", a_count, qa.size()); end
    compared++; if (b_valid !== 1'b0) begin mismatched++; $display("FAIL single_b_valid got=%0h exp=0", b_valid); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy got=%0h exp=1", busy); end
    a_ready = 1'b1;
    e = (qa.size() != 0) ? qa.pop_front() : 6'h00;
    compared++; if (a_data !== e) begin mismatched++; $display("FAIL single_a_data got=%0h exp=%0h", a_data, e); end
    next_cycle();
    a_ready = 1'b0;
    compared++; if (a_valid !== 1'b0) begin mismatched++; $display("FAIL single_a_drained got=%0h exp=0", a_valid); end
    compared++; if (a_data !== 6'h00) begin mismatched++; $display("FAIL single_a_data_idle got=%0h exp=0", a_data); end
  endtask

  task automatic test_fill_b();
    logic [5:0] vals [2];
    vals[0] = 6'h01; vals[1] = 6'h02;
    b_ready = 1'b0; a_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = 1'b1; in_data = vals[i]; in_valid = 1'b1; #1;
      exp_rdy = (qb.size() != DEPTH);
      compared++; if (in_ready !== exp_rdy) begin mismatched++; $display("FAIL fill_in_ready%0d got=%0h exp=%0h", i, in_ready, exp_rdy); end
      if (exp_rdy) qb.push_back(in_data);
      next_cycle();
    end
    in_valid = 1'b0;
    compared++; if (b_count !== 2'd2) begin mismatched++; $display("FAIL fill_b_count got=%0d exp=2", b_count); end
    s = 1'b1; #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL fill_ready_s1 got=%0h exp=0", in_ready); end
    s = 1'b0; #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL fill_ready_s0 got=%0h exp=1", in_ready); end
    in_data = 6'h3F; in_valid = 1'b1;
    qa.push_back(in_data);
    next_cycle();
    in_valid = 1'b0;
    compared++; if (a_count !== 2'd1) begin mismatched++; $display("FAIL fill_a_count got=%0d exp=1", a_count); end
    compared++; if (b_count !== 2'd2) begin mismatched++; $display("FAIL fill_b_unchanged got=%0d exp=2", b_count); end
    compared++; if (b_data !== qb[0]) begin mismatched++; $display("FAIL fill_b_head got=%0h exp=%0h", b_data, qb[0]); end
    a_ready = 1'b1;
    e = qa.pop_front();
    compared++; if (a_data !== e) begin mismatched++; $display("FAIL fill_a_data got=%0h exp=%0h", a_data, e); end
    next_cycle();
    a_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    s = 1'b1; in_data = 6'h2A; in_valid = 1'b1; b_ready = 1'b1; #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL fullpop_blocked got=%0h exp=0", in_ready); end
    e = qb.pop_front();
    compared++; if (b_data !== e) begin mismatched++; $display("FAIL fullpop_head0 got=%0h exp=%0h", b_data, e); end
    next_cycle();
    compared++; if (b_count !== 2'd1) begin mismatched++; $display("FAIL fullpop_count1 got=%0d exp=1", b_count); end
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL fullpop_ready got=%0h exp=1", in_ready); end
    e = qb.pop_front();
    compared++; if (b_data !== e) begin mismatched++; $display("FAIL fullpop_head1 got=%0h exp=%0h", b_data, e); end
    qb.push_back(in_data);
    next_cycle();
    in_valid = 1'b0;
    compared++; if (b_count !== 2'd1) begin mismatched++; $display("FAIL fullpop_count_hold got=%0d exp=1", b_count); end
    e = qb.pop_front();
    compared++; if (b_data !== e) begin mismatched++; $display("FAIL fullpop_head2 got=%0h exp=%0h", b_data, e); end
    next_cycle();
    b_ready = 1'b0;
    compared++; if (b_count !== 2'd0) begin mismatched++; $display("FAIL fullpop_empty got=%0d exp=0", b_count); end
  endtask

  task automatic test_stream();
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_valid = (i < 10);
      s = i[0];
      in_data = 6'(i);
      #1;
      compared++; if (a_valid !== (qa.size() != 0)) begin mismatched++; $display("FAIL stream_a_valid%0d got=%0h exp=%0h", i, a_valid, qa.size() != 0); end
      compared++; if (b_valid !== (qb.size() != 0)) begin mismatched++; $display("FAIL stream_b_valid%0d got=%0h exp=%0h", i, b_valid, qb.size() != 0); end
      if (qa.size() != 0) begin
        e = qa.pop_front();
        compared++; if (a_data !== e) begin mismatched++; $display("FAIL stream_a_data%0d got=%0h exp=%0h", i, a_data, e); end
      end
      if (qb.size() != 0) begin
        e = qb.pop_front();
        compared++; if (b_data !== e) begin mismatched++; $display("FAIL stream_b_data%0d got=%0h exp=%0h", i, b_data, e); end
      end
      exp_rdy = s ? (qb.size() != DEPTH) : (qa.size() != DEPTH);
      if (in_valid) begin
        compared++; if (in_ready !== exp_rdy) begin mismatched++; $display("FAIL stream_in_ready%0d got=%0h exp=%0h", i, in_ready, exp_rdy); end
        if (exp_rdy) begin
          if (s) qb.push_back(in_data); else qa.push_back(in_data);
        end
      end
      next_cycle();
      compared++; if (a_count > 2'd1 || b_count > 2'd1) begin mismatched++; $display("FAIL stream_count%0d got=%0d/%0d exp<=1", i, a_count, b_count); end
    end
    in_valid = 1'b0;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL stream_drained_busy got=%0h exp=0", busy); end
    a_ready = 1'b0; b_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    s = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 6'(6'h20 + i);
      qa.push_back(in_data);
      next_cycle();
    end
    compared++; if (a_count !== 2'd2) begin mismatched++; $display("FAIL rmid_filled got=%0d exp=2", a_count); end
    reset = 1'b1; s = 1'b1; in_data = 6'h11; in_valid = 1'b1;
    next_cycle();
    reset = 1'b0; in_valid = 1'b0;
    qa.delete(); qb.delete();
    compared++; if (a_count !== 2'd0) begin mismatched++; $display("FAIL rmid_a_count got=%0d exp=0", a_count); end
    compared++; if (b_count !== 2'd0) begin mismatched++; $display("FAIL rmid_b_count got=%0d exp=0", b_count); end
    compared++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_valids got=%0h%0h exp=00", a_valid, b_valid); end
    compared++; if (a_data !== 6'h00) begin mismatched++; $display("FAIL rmid_a_data got=%0h exp=0", a_data); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rmid_busy got=%0h exp=0", busy); end
    next_cycle();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rmid_quiet got=%0h exp=0", busy); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; s = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    next_cycle();
    test_reset();
    test_single_a();
    test_fill_b();
    test_full_pop();
    test_stream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/demux6b2_stream.md
Name: demux6b2_stream

Overview:
- Registered 1-to-2 stream demultiplexer: the inverse of the 6-bit 2:1 select mux.
- Accepts one WIDTH-bit word per handshake and steers it by select s into one of two output lanes (a for s=0, b for s=1).
- Each lane has its own DEPTH-entry FIFO with a valid/ready interface.
- Sits between a single producer and two independent consumers in the lab datapath, e.g. splitting decoded register indices toward two units.

Parameters:
- WIDTH, 6: data width of every word in and out.
- DEPTH, 2: entries per lane FIFO. Must be a power of 2, >= 2. Pointer width PW = log2(DEPTH); count width PW+1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- s  input  1  lane select: 0 routes to lane a, 1 routes to lane b. Sampled with in_data.
- in_valid  input  1  producer has a word.
- in_ready  output  1  demux can accept the word for the currently selected lane.
- a_data  output  WIDTH  head of lane-a FIFO.
- a_valid  output  1  lane a non-empty.
- a_ready  input  1  lane-a consumer takes head.
- b_data  output  WIDTH  head of lane-b FIFO.
- b_valid  output  1  lane b non-empty.
- b_ready  input  1  lane-b consumer takes head.
- a_count  output  PW+1  lane-a occupancy, 0..DEPTH.
- b_count  output  PW+1  lane-b occupancy, 0..DEPTH.
- busy  output  1  either lane non-empty.

Behaviour:
- Reset (synchronous, wins over all activity in the same cycle):
  - Pointers and counts cleared to 0.
  - a_valid = b_valid = 0, busy = 0.
  - a_data = b_data = 0. Storage contents need not be cleared.
  - Reset mid-transfer discards all queued words; no word is emitted after reset until a new push.
- in_ready (combinational from s and counts):
  - s=0: in_ready = (a_count != DEPTH).
  - s=1: in_ready = (b_count != DEPTH).
  - Does not depend on a_ready or b_ready. A full lane blocks even if it pops this cycle; there is no pass-through.
- Push:
  - Occurs when in_valid && in_ready at a rising edge.
  - in_data is written at the selected lane's write pointer, which then increments modulo DEPTH.
  - The unselected lane is untouched.
- Pop:
  - a_valid && a_ready advances lane-a read pointer modulo DEPTH. Lane b is symmetric.
  - Ready while not valid is ignored; no underflow, count stays 0.
- Latency: a word pushed at edge N appears on x_valid/x_data after edge N (visible in cycle N+1). Minimum 1 cycle, no combinational in-to-out path.
- x_valid = (x_count != 0).
- x_data = storage[read pointer] when valid, else 0.
- Ordering: per-lane order is strictly preserved. No ordering relation between lanes.
- Count update per lane:
  - push only: +1.
  - pop only: -1.
  - push and pop same edge (lane not full): unchanged; pointers both advance.
- Simultaneous push to one lane and pop from the other are independent.
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no bubble; data integrity holds across the wrap.
- busy = a_valid | b_valid.
- s and in_data changing while in_valid is high and in_ready is low is legal. Routing uses s only at the accepting edge.

Test Plan:
- Reset then idle -> a_valid=b_valid=0, counts 0, a_data=b_data=0, in_ready=1 for s=0 and s=1, busy=0.
- Push 6'h15 with s=0, a_ready=0 -> next cycle a_valid=1, a_data=6'h15, a_count=1; b_valid=0; assert a_ready one cycle -> a_valid=0.
- Push 6'h01, 6'h02 to lane b (DEPTH=2) with b_ready=0 -> b_count=2 and in_ready=0 for s=1, while in_ready=1 for s=0. Push 6'h3F on s=0 -> accepted on a, b unchanged.
- Lane b full, b_ready=1 and in_valid=1, s=1 same cycle -> no push (in_ready=0), b_count 2->1, b_data=6'h02. Next cycle push succeeds, b_count stays 1.
- Stream 6'h00..6'h09 alternating s with a_ready=b_ready=1 -> a emits 00,02,04,06,08 and b emits 01,03,05,07,09 in order; pointers wrap several times; counts never exceed 1.
- Fill lane a to 2, assert reset with in_valid=1 -> next cycle all counts 0, valids 0, nothing accepted in the reset cycle.
